cache_axi_dm: RTL and testbench
===============================

CACHE_AXI_DM -- requirements
Module: cache_axi_dm

Interface
REQ-001 Parameter LINES, default 4, number of direct-mapped lines; power of two, at least 2.
REQ-002 Parameter LINE_WORDS, default 16, 32-bit words per line; power of two, 2..256.
REQ-003 CLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 STALL  in  1  holds the read-response registers.
REQ-006 FLUSH  in  1  invalidates all lines.
REQ-007 HIT_CHECK  in  32  probe address; HIT_CHECK_RESULT  out  1  probe result.
REQ-008 RDEN  in  1, RIADDR  in  32  read request; ROADDR  out  32, RVALID  out  1, RDATA  out  32  read response.
REQ-009 WREN  in  1, WADDR  in  32, WSTRB  in  4, WDATA  in  32  store into cache.
REQ-010 ERR  out  1  refill bus-error pulse.
REQ-011 M_AXI_ARADDR  out  32, M_AXI_ARLEN  out  8, M_AXI_ARSIZE  out  3, M_AXI_ARBURST  out  2, M_AXI_ARVALID  out  1, M_AXI_ARREADY  in  1.
REQ-012 M_AXI_RDATA  in  32, M_AXI_RRESP  in  2, M_AXI_RLAST  in  1, M_AXI_RVALID  in  1, M_AXI_RREADY  out  1.
REQ-013 HIT_COUNT  out  32, MISS_COUNT  out  32  performance counters.

Function
REQ-014 Address split: [1:0] byte, next log2(LINE_WORDS) bits word, next log2(LINES) bits index, remainder tag.
REQ-015 hit(a) = valid[index(a)] and tag[index(a)] == tag(a).
REQ-016 HIT_CHECK_RESULT = !RDEN or hit(HIT_CHECK), combinational.
REQ-017 When STALL=0, the next edge loads ROADDR<=RIADDR, RVALID<=RDEN and hit(RIADDR), and RDATA<=the addressed word on hit, else 0; latency one cycle.
REQ-018 When STALL=1, ROADDR, RVALID and RDATA hold.
REQ-019 WREN with hit(WADDR) merges WDATA into the addressed word byte-wise per WSTRB bit; WREN on a miss is dropped.
REQ-020 When WREN and RDEN target the same hit word in one cycle, RDATA returns the merged value.
REQ-021 Refill FSM states are IDLE, ADDR and DATA.
REQ-022 IDLE -> ADDR on RDEN and miss(RIADDR): latch {tag,index,0} as ARADDR and clear valid[index].
REQ-023 ADDR: ARVALID=1; ARREADY -> DATA, ARVALID=0 next cycle.
REQ-024 DATA: RREADY=1; each RVALID beat writes word[cnt] and increments cnt; RVALID and RLAST -> IDLE.
REQ-025 At the last beat, tag and valid are written only if no beat had RRESP!=0 and no FLUSH occurred during the refill; otherwise the line stays invalid and ERR pulses one cycle (error case only).
REQ-026 ARLEN=LINE_WORDS-1; ARSIZE=3'b010; ARBURST=2'b01.
REQ-027 FLUSH clears all valid bits at the next edge; the refill in flight completes on the bus without validating.
REQ-028 A WREN hitting another line during DATA is performed; the line under refill never hits.
REQ-029 Reset values: RVALID=0, RDATA=0, ROADDR=0, ARVALID=0, ARADDR=0, RREADY=0, ERR=0, counters 0.

Reset
REQ-030 RST, including mid-refill, forces IDLE, clears all valid bits, cnt and outputs per REQ-029; data array contents are not reset.
REQ-031 RST SHALL be applied to the AXI slave in the same cycle; beats arriving after RST are ignored.

Configuration
REQ-032 Macro CACHE_AXI_DM_PERF_CNT_EN defined: HIT_COUNT increments on each non-stalled RDEN hit cycle; MISS_COUNT increments once per refill start; both wrap at 2^32.
REQ-033 CACHE_AXI_DM_PERF_CNT_EN undefined: HIT_COUNT and MISS_COUNT are constant 0 and no counter logic exists.

Verification (LINES=4, LINE_WORDS=16)
REQ-034 Cold read 0x0000_1044 -> ARADDR 0x0000_1040, ARLEN 0x0F; 16 beats of value 0xA0+k; re-presented request gives RVALID=1 and RDATA 0xA1.
REQ-035 After REQ-034, read 0x0000_104C -> next cycle RVALID=1, RDATA 0xA3, with no AR transaction.
REQ-036 Word 0x1048 holds 0x11223344; same-cycle WREN 0x1048, WSTRB 4'b0001, WDATA 0xAB, and RDEN 0x1048 -> RDATA 0x112233AB.
REQ-037 Read 0x0000_2040, which has the same index -> refill; afterwards 0x1040 gives HIT_CHECK_RESULT=0 with RDEN=1, and MISS_COUNT=2 (macro on).
REQ-038 RRESP=2'b10 on beat 5 -> ERR=1 one cycle at RLAST, line invalid, and RVALID stays 0.
REQ-039 FLUSH=1 mid-DATA -> burst completes, all lines invalid, and HIT_CHECK 0x1040 result 0.

Source files
------------

// File: rtl/cache_axi_dm.sv
// Direct-mapped read/write cache with an AXI4 burst refill port.
// Optional performance counters: define CACHE_AXI_DM_PERF_CNT_EN.
module cache_axi_dm #(
  parameter int LINES      = 4,
  parameter int LINE_WORDS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] HIT_CHECK,
  output logic        HIT_CHECK_RESULT,
  input  logic        RDEN,
  input  logic [31:0] RIADDR,
  output logic [31:0] ROADDR,
  output logic        RVALID,
  output logic [31:0] RDATA,
  input  logic        WREN,
  input  logic [31:0] WADDR,
  input  logic [3:0]  WSTRB,
  input  logic [31:0] WDATA,
  output logic        ERR,
  output logic [31:0] M_AXI_ARADDR,
  output logic [7:0]  M_AXI_ARLEN,
  output logic [2:0]  M_AXI_ARSIZE,
  output logic [1:0]  M_AXI_ARBURST,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RLAST,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  output logic [31:0] HIT_COUNT,
  output logic [31:0] MISS_COUNT
);
  localparam int WB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(LINES);
  localparam int IL = WB + 2;
  localparam int TL = IL + IB;
  localparam int TW = 32 - TL;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  logic [31:0]      mem [LINES*LINE_WORDS];
  logic [TW-1:0]    tag_q [LINES];
  logic [LINES-1:0] valid_q;
  state_t           state_q, state_d;
  logic [WB-1:0]    cnt_q;
  logic [IB-1:0]    ref_idx_q;
  logic [TW-1:0]    ref_tag_q;
  logic             bad_q, fl_q;
  logic             hit_rd, hit_wr, hit_chk, wr_do, start, beat, last, bad_now, fill_ok;
  logic [31:0]      wr_old, wr_new, rd_word;
  logic             unused_bits;

  assign unused_bits = ^{RIADDR[1:0], WADDR[1:0], HIT_CHECK[1:0]};

  assign hit_rd  = valid_q[RIADDR[TL-1:IL]]    && (tag_q[RIADDR[TL-1:IL]]    == RIADDR[31:TL]);
  assign hit_wr  = valid_q[WADDR[TL-1:IL]]     && (tag_q[WADDR[TL-1:IL]]     == WADDR[31:TL]);
  assign hit_chk = valid_q[HIT_CHECK[TL-1:IL]] && (tag_q[HIT_CHECK[TL-1:IL]] == HIT_CHECK[31:TL]);
  assign HIT_CHECK_RESULT = !RDEN || hit_chk;

  assign wr_do   = WREN && hit_wr;
  assign start   = (state_q == IDLE) && RDEN && !hit_rd;
  assign beat    = (state_q == DATA) && M_AXI_RVALID;
  assign last    = beat && M_AXI_RLAST;
  assign bad_now = bad_q || (beat && M_AXI_RRESP != 2'b00);
  assign fill_ok = !bad_now && !fl_q && !FLUSH;

  assign M_AXI_ARLEN   = 8'(LINE_WORDS - 1);
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;

  // Byte merge; a same-cycle read of the written word sees the merged value.
  always_comb begin
    wr_old = mem[WADDR[TL-1:2]];
    wr_new = wr_old;
    for (int b = 0; b < 4; b++)
      if (WSTRB[b]) wr_new[8*b +: 8] = WDATA[8*b +: 8];
    rd_word = (wr_do && WADDR[31:2] == RIADDR[31:2]) ? wr_new : mem[RIADDR[TL-1:2]];
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADDR;
      ADDR:    if (M_AXI_ARREADY) state_d = DATA;
      DATA:    if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (state_q)
      ADDR:    M_AXI_ARVALID = 1'b1;
      DATA:    M_AXI_RREADY  = 1'b1;
      default: ;
    endcase
  end

  // Storage arrays carry no reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (wr_do) mem[WADDR[TL-1:2]] <= wr_new;
      if (beat) mem[{ref_idx_q, cnt_q}] <= M_AXI_RDATA;
      if (last && fill_ok) tag_q[ref_idx_q] <= ref_tag_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0; cnt_q <= '0; ref_idx_q <= '0; ref_tag_q <= '0;
      bad_q <= 1'b0; fl_q <= 1'b0; ERR <= 1'b0; M_AXI_ARADDR <= '0;
      ROADDR <= '0; RVALID <= 1'b0; RDATA <= '0;
    end else begin
      ERR <= 1'b0;
      if (!STALL) begin
        ROADDR <= RIADDR;
        RVALID <= RDEN && hit_rd;
        RDATA  <= hit_rd ? rd_word : 32'd0;
      end
      if (start) begin
        M_AXI_ARADDR <= {RIADDR[31:IL], {IL{1'b0}}};
        ref_idx_q <= RIADDR[TL-1:IL];
        ref_tag_q <= RIADDR[31:TL];
        valid_q[RIADDR[TL-1:IL]] <= 1'b0;
        cnt_q <= '0; bad_q <= 1'b0; fl_q <= 1'b0;
      end
      if (state_q != IDLE && FLUSH) fl_q <= 1'b1;
      if (beat) begin
        cnt_q <= cnt_q + 1'b1;
        if (M_AXI_RRESP != 2'b00) bad_q <= 1'b1;
      end
      if (last) begin
        if (fill_ok) valid_q[ref_idx_q] <= 1'b1;
        ERR <= bad_now;
      end
      // Flush last so it overrides any validate in the same cycle.
      if (FLUSH) valid_q <= '0;
    end
  end

`ifdef CACHE_AXI_DM_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      HIT_COUNT <= '0; MISS_COUNT <= '0;
    end else begin
      if (!STALL && RDEN && hit_rd) HIT_COUNT <= HIT_COUNT + 32'd1;
      if (start) MISS_COUNT <= MISS_COUNT + 32'd1;
    end
  end
`else
  assign HIT_COUNT  = 32'd0;
  assign MISS_COUNT = 32'd0;
`endif
endmodule

// File: tb/tb_cache_axi_dm.sv
// Bench for cache_axi_dm: directed vector table, corner sequences and random traffic vs a line-level model.
module tb_cache_axi_dm;
  localparam int LINES = 4;
  localparam int LW    = 16;

  logic clk = 0, rst = 0, stall = 0, flush = 0, rden = 0, wren = 0;
  logic [31:0] hit_check = 0, riaddr = 0, waddr = 0, wdata = 0;
  logic [3:0]  wstrb = 0;
  logic arready = 0, s_rlast = 0, s_rvalid = 0;
  logic [31:0] s_rdata = 0;
  logic [1:0]  s_rresp = 0;
  logic        HIT_CHECK_RESULT, RVALID, ERR, M_AXI_ARVALID, M_AXI_RREADY;
  logic [31:0] ROADDR, RDATA, M_AXI_ARADDR, HIT_COUNT, MISS_COUNT;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;

  cache_axi_dm #(.LINES(LINES), .LINE_WORDS(LW)) dut (
    .CLK(clk), .RST(rst), .STALL(stall), .FLUSH(flush),
    .HIT_CHECK(hit_check), .HIT_CHECK_RESULT(HIT_CHECK_RESULT),
    .RDEN(rden), .RIADDR(riaddr), .ROADDR(ROADDR), .RVALID(RVALID), .RDATA(RDATA),
    .WREN(wren), .WADDR(waddr), .WSTRB(wstrb), .WDATA(wdata), .ERR(ERR),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp), .M_AXI_RLAST(s_rlast),
    .M_AXI_RVALID(s_rvalid), .M_AXI_RREADY(M_AXI_RREADY),
    .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Reference model: cache contents as lines of words plus one pending refill.
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  logic [31:0] m_data  [LINES][LW];
  bit          busy, ref_bad, ref_fl, beat_now;
  int unsigned ref_line, ref_tagv, beat_k;
  logic [31:0] ref_addr, ref_buf [LW];
  logic [31:0] exp_roaddr, exp_rdata;
  logic        exp_rvalid, exp_err;
  int unsigned exp_hc, exp_mc;

  function automatic int unsigned f_idx(logic [31:0] a);  return (a / (4*LW)) % LINES; endfunction
  function automatic int unsigned f_tag(logic [31:0] a);  return a / (4*LW*LINES);     endfunction
  function automatic int unsigned f_word(logic [31:0] a); return (a / 4) % LW;         endfunction
  function automatic bit mhit(logic [31:0] a);
    int unsigned i = f_idx(a);
    return m_valid[i] && m_tag[i] == f_tag(a);
  endfunction

  function automatic logic [31:0] rnd_addr();
    return 32'((($urandom % 3) + 1) * 256 + ($urandom % 4) * 64 + ($urandom % 16) * 4 + ($urandom % 4));
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    busy = 0; beat_k = 0; ref_bad = 0; ref_fl = 0;
    exp_roaddr = 0; exp_rdata = 0; exp_rvalid = 0; exp_err = 0; exp_hc = 0; exp_mc = 0;
  endtask

  task automatic idle_inputs();
    rden = 0; wren = 0; stall = 0; flush = 0;
  endtask

  task automatic rnd_traffic();
    rden = ($urandom % 2) == 0; riaddr = rnd_addr();
    wren = ($urandom % 3) == 0; waddr = rnd_addr(); wstrb = 4'($urandom); wdata = $urandom;
    stall = ($urandom % 6) == 0; hit_check = rnd_addr();
  endtask

  // One clock: check the probe, advance the model across the edge, check registered outputs.
  task automatic step();
    bit rh, wh, was_busy;
    int unsigned li, wi;
    #1;
    chk("hit_check_result", 32'(HIT_CHECK_RESULT), 32'(!rden || mhit(hit_check)));
    if (rst) reset_model();
    else begin
      was_busy = busy;
      rh = mhit(riaddr);
      wh = wren && mhit(waddr);
      if (wh) begin
        li = f_idx(waddr); wi = f_word(waddr);
        for (int b = 0; b < 4; b++) if (wstrb[b]) m_data[li][wi][8*b +: 8] = wdata[8*b +: 8];
      end
      if (!stall) begin
        exp_roaddr = riaddr;
        exp_rvalid = rden && rh;
        exp_rdata  = rh ? m_data[f_idx(riaddr)][f_word(riaddr)] : 32'd0;
        if (rden && rh) exp_hc++;
      end
      exp_err = 0;
      if (busy && flush) ref_fl = 1;
      if (beat_now) begin
        ref_buf[beat_k] = s_rdata;
        if (s_rresp != 0) ref_bad = 1;
        beat_k++;
        if (s_rlast) begin
          if (!ref_bad && !ref_fl) begin
            m_valid[ref_line] = 1; m_tag[ref_line] = ref_tagv;
            for (int w = 0; w < LW; w++) m_data[ref_line][w] = ref_buf[w];
          end
          exp_err = ref_bad;
          busy = 0;
        end
      end
      if (!was_busy && rden && !rh) begin
        busy = 1; ref_line = f_idx(riaddr); ref_tagv = f_tag(riaddr);
        ref_addr = riaddr - riaddr % (4*LW);
        ref_bad = 0; ref_fl = 0; beat_k = 0;
        m_valid[ref_line] = 0;
        exp_mc++;
      end
      if (flush) for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    end
    @(posedge clk); #1;
    chk("roaddr", ROADDR, exp_roaddr);
    chk("rvalid", 32'(RVALID), 32'(exp_rvalid));
    chk("rdata", RDATA, exp_rdata);
    chk("err", 32'(ERR), 32'(exp_err));
`ifdef CACHE_AXI_DM_PERF_CNT_EN
    chk("hit_count", HIT_COUNT, exp_hc);
    chk("miss_count", MISS_COUNT, exp_mc);
`else
    chk("hit_count_off", HIT_COUNT, 32'd0);
    chk("miss_count_off", MISS_COUNT, 32'd0);
`endif
  endtask

  // AXI slave for one refill; beat k may carry an error response or coincide with FLUSH.
  task automatic serve(input bit seq, input int err_beat, input int fl_beat, input bit traffic,
                       output bit err_seen);
    bit got = 0;
    int k = 0, cyc = 0;
    err_seen = 0;
    if (!traffic) idle_inputs();
    for (int w = 0; w < 8; w++) begin
      if (M_AXI_ARVALID) begin got = 1; break; end
      step();
    end
    chk("ar_wait", 32'(got), 32'd1);
    if (!got) return;
    chk("araddr", M_AXI_ARADDR, ref_addr);
    chk("arlen", 32'(M_AXI_ARLEN), 32'(LW - 1));
    chk("arsize", 32'(M_AXI_ARSIZE), 32'd2);
    chk("arburst", 32'(M_AXI_ARBURST), 32'd1);
    arready = 1;
    if (traffic) rnd_traffic();
    step();
    arready = 0;
    chk("arvalid_drop", 32'(M_AXI_ARVALID), 32'd0);
    chk("rready", 32'(M_AXI_RREADY), 32'd1);
    while (k < LW && cyc < 100) begin
      cyc++;
      beat_now = 0; s_rvalid = 0; s_rlast = 0; s_rresp = 0; flush = 0;
      if (traffic) rnd_traffic();
      if (!traffic || ($urandom % 4) != 0) begin
        s_rvalid = 1; beat_now = 1;
        s_rdata = seq ? 32'(32'hA0 + k) : $urandom;
        s_rresp = (k == err_beat) ? 2'b10 : 2'b00;
        s_rlast = (k == LW - 1);
        flush = (k == fl_beat);
        k++;
      end
      step();
      if (s_rlast) err_seen = ERR;
    end
    beat_now = 0; s_rvalid = 0; s_rlast = 0; s_rresp = 0;
    idle_inputs();
  endtask

  typedef struct {
    logic rden; logic [31:0] riaddr;
    logic wren; logic [31:0] waddr; logic [3:0] wstrb; logic [31:0] wdata;
    logic stall; logic exp_rvalid; logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    bit e;
    tbl[0] = '{1'b1, 32'h1044, 1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b1, 32'hA1};
    tbl[1] = '{1'b1, 32'h104C, 1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b1, 32'hA3};
    tbl[2] = '{1'b0, 32'h3000, 1'b1, 32'h1048, 4'hF, 32'h11223344, 1'b0, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 32'h1048, 1'b1, 32'h1048, 4'h1, 32'hAB,       1'b0, 1'b1, 32'h112233AB};
    tbl[4] = '{1'b1, 32'h1048, 1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b1, 32'h112233AB};
    tbl[5] = '{1'b1, 32'h1044, 1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 1'b1, 32'h112233AB};
    tbl[6] = '{1'b1, 32'h1048, 1'b1, 32'h2048, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h112233AB};
    tbl[7] = '{1'b1, 32'h1078, 1'b1, 32'h1078, 4'hC, 32'hDEAD0000, 1'b0, 1'b1, 32'hDEAD00AE};

    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    reset_model();
    chk("rst_rvalid", 32'(RVALID), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_roaddr", ROADDR, 32'd0);
    chk("rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
    chk("rst_araddr", M_AXI_ARADDR, 32'd0);
    chk("rst_rready", 32'(M_AXI_RREADY), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_hit_count", HIT_COUNT, 32'd0);
    chk("rst_miss_count", MISS_COUNT, 32'd0);
    rst = 0;

    // Cold miss with incrementing burst data.
    rden = 1; riaddr = 32'h1044; hit_check = 32'h1044;
    step();
    chk("cold_araddr", M_AXI_ARADDR, 32'h1040);
    chk("cold_arlen", 32'(M_AXI_ARLEN), 32'h0F);
    serve(1, -1, -1, 0, e);

    for (int i = 0; i < 8; i++) begin
      rden = tbl[i].rden; riaddr = tbl[i].riaddr; wren = tbl[i].wren; waddr = tbl[i].waddr;
      wstrb = tbl[i].wstrb; wdata = tbl[i].wdata; stall = tbl[i].stall;
      step();
      chk($sformatf("vec%0d_rvalid", i), 32'(RVALID), 32'(tbl[i].exp_rvalid));
      chk($sformatf("vec%0d_rdata", i), RDATA, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_no_ar", i), 32'(M_AXI_ARVALID), 32'd0);
    end
    idle_inputs();

    // Conflict miss on the same index evicts 0x1040.
    rden = 1; riaddr = 32'h2040;
    step();
    serve(0, -1, -1, 0, e);
    rden = 1; riaddr = 32'h2040; hit_check = 32'h1040;
    #1 chk("evicted_probe", 32'(HIT_CHECK_RESULT), 32'd0);
    step();
`ifdef CACHE_AXI_DM_PERF_CNT_EN
    chk("miss_count_2", MISS_COUNT, 32'd2);
`endif

    // Error response on beat 5.
    rden = 1; riaddr = 32'h3080;
    step();
    serve(0, 5, -1, 0, e);
    chk("err_pulse", 32'(e), 32'd1);
    chk("err_rvalid", 32'(RVALID), 32'd0);
    step();
    chk("err_one_cycle", 32'(ERR), 32'd0);
    rden = 1; riaddr = 32'h2040; hit_check = 32'h3080;
    #1 chk("err_line_invalid", 32'(HIT_CHECK_RESULT), 32'd0);
    step();

    // FLUSH in the middle of the data phase.
    rden = 1; riaddr = 32'h30C0;
    step();
    serve(0, -1, 7, 0, e);
    chk("flush_no_err", 32'(e), 32'd0);
    rden = 1; riaddr = 32'h1040; hit_check = 32'h1040;
    #1 chk("flush_probe", 32'(HIT_CHECK_RESULT), 32'd0);
    step();
    serve(0, -1, -1, 1, e);

    // Random traffic, refills served with background reads and writes.
    for (int n = 0; n < 400; n++) begin
      rnd_traffic();
      flush = ($urandom % 40) == 0;
      step();
      flush = 0;
      if (busy)
        serve(0, (($urandom % 6) == 0) ? int'($urandom % LW) : -1,
                 (($urandom % 10) == 0) ? int'($urandom % LW) : -1, 1, e);
    end
    idle_inputs();

    // Reset in the middle of a refill; stray beats afterwards are ignored.
    flush = 1; step(); flush = 0;
    rden = 1; riaddr = 32'h10C4;
    step();
    rden = 0;
    chk("mid_arvalid", 32'(M_AXI_ARVALID), 32'd1);
    arready = 1; step(); arready = 0;
    for (int k = 0; k < 3; k++) begin
      s_rvalid = 1; s_rdata = $urandom; beat_now = 1;
      step();
    end
    s_rvalid = 0; beat_now = 0;
    rst = 1; step(); rst = 0;
    chk("mid_rst_rready", 32'(M_AXI_RREADY), 32'd0);
    chk("mid_rst_araddr", M_AXI_ARADDR, 32'd0);
    for (int k = 0; k < 4; k++) begin
      s_rvalid = 1; s_rdata = $urandom; s_rlast = (k == 3);
      step();
      chk("stray_rready", 32'(M_AXI_RREADY), 32'd0);
      chk("stray_arvalid", 32'(M_AXI_ARVALID), 32'd0);
    end
    s_rvalid = 0; s_rlast = 0;
    rden = 1; riaddr = 32'h10C4; hit_check = 32'h10C4;
    #1 chk("post_rst_invalid", 32'(HIT_CHECK_RESULT), 32'd0);
    step();
    serve(0, -1, -1, 0, e);
    rden = 1; riaddr = 32'h10C4;
    step();
    chk("post_rst_refill_hit", 32'(RVALID), 32'd1);
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
